// File: rtl/wave_ctrl.sv
// wave_ctrl: debounces four buttons and steps the waveform select, amplitude,
// period and prescale settings, with a prescaler phase and a restart strobe.
module wave_ctrl #(
  parameter logic [19:0] DEB_CYCLES = 20'd1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_func,
  input  logic       btn_amp,
  input  logic       btn_peri,
  input  logic       btn_freq,
  output logic [2:0] func_cnt,
  output logic [2:0] amp_cnt,
  output logic [2:0] peri_cnt,
  output logic [2:0] freq_dy,
  output logic [2:0] peri_posedge,
  output logic [1:0] freq_sel
);
  typedef enum logic [1:0] {IDLE, CHK_PRESS, HELD, CHK_REL} deb_t;
  localparam logic [19:0] LAST = DEB_CYCLES - 20'd1;
  logic [3:0] w_btn;
  logic [3:0] w_press;
  logic [3:0] r_s1;
  logic [3:0] r_s2;
  logic       r_upd;
  assign w_btn = {btn_freq, btn_peri, btn_amp, btn_func};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_btn;
      r_s2 <= r_s1;
    end
  end
  for (genvar i = 0; i < 4; i++) begin : g_deb
    deb_t        r_st;
    logic [19:0] r_cnt;
    // press pulse is combinational so the setting lands on the FSM's HELD transition edge
    assign w_press[i] = (r_st == CHK_PRESS) && r_s2[i] && (r_cnt == LAST);
    always_ff @(posedge clk) begin
      if (rst) begin
        r_st  <= IDLE;
        r_cnt <= '0;
      end else begin
        case (r_st)
          IDLE: if (r_s2[i]) begin
            r_st  <= CHK_PRESS;
            r_cnt <= '0;
          end
          CHK_PRESS: if (!r_s2[i]) r_st <= IDLE;
            else if (r_cnt == LAST) r_st <= HELD;
            else r_cnt <= r_cnt + 20'd1;
          HELD: if (!r_s2[i]) begin
            r_st  <= CHK_REL;
            r_cnt <= '0;
          end
          CHK_REL: if (r_s2[i]) r_st <= HELD;
            else if (r_cnt == LAST) r_st <= IDLE;
            else r_cnt <= r_cnt + 20'd1;
          default: r_st <= IDLE;
        endcase
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      func_cnt     <= '0;
      amp_cnt      <= '0;
      peri_cnt     <= '0;
      freq_sel     <= '0;
      freq_dy      <= '0;
      r_upd        <= 1'b0;
      peri_posedge <= '0;
    end else begin
      if (w_press[0]) func_cnt <= (func_cnt == 3'd4) ? 3'd0 : func_cnt + 3'd1;
      if (w_press[1]) amp_cnt <= {1'b0, amp_cnt[1:0] + 2'd1};
      if (w_press[2]) peri_cnt <= {1'b0, peri_cnt[1:0] + 2'd1};
      if (w_press[3]) freq_sel <= freq_sel + 2'd1;
      freq_dy      <= (w_press[3] || freq_dy == {1'b0, freq_sel}) ? 3'd0 : freq_dy + 3'd1;
      r_upd        <= w_press[0] | w_press[2] | w_press[3];
      peri_posedge <= {2'b00, r_upd};
    end
  end
endmodule

// File: tb/tb_wave_ctrl.sv
// tb_wave_ctrl: directed and random button stimulus checked every cycle against
// a run-length debounce model of the settings, prescaler phase and strobe.
module tb_wave_ctrl;
  localparam int DEB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_func = 1'b0, btn_amp = 1'b0, btn_peri = 1'b0, btn_freq = 1'b0;
  logic [2:0] func_cnt, amp_cnt, peri_cnt, freq_dy, peri_posedge;
  logic [1:0] freq_sel;
  int n_chk = 0, n_fail = 0, pp_cnt = 0;
  logic [3:0] h1, h2, lvl, rnd;
  int run[4];
  int m_func, m_amp, m_peri, m_sel, m_k;
  logic m_upd, m_pp;

  always #5 clk = ~clk;

  wave_ctrl #(.DEB_CYCLES(20'd4)) dut (
    .clk(clk), .rst(rst),
    .btn_func(btn_func), .btn_amp(btn_amp), .btn_peri(btn_peri), .btn_freq(btn_freq),
    .func_cnt(func_cnt), .amp_cnt(amp_cnt), .peri_cnt(peri_cnt),
    .freq_dy(freq_dy), .peri_posedge(peri_posedge), .freq_sel(freq_sel)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model: a button's accepted level flips after DEB+1 consecutive synced
  // samples that disagree with it; synced input is the raw level two edges old.
  task automatic step(input logic [3:0] b, input logic r);
    logic [3:0] p;
    {btn_freq, btn_peri, btn_amp, btn_func} = b;
    rst = r;
    @(posedge clk);
    p = '0;
    if (r) begin
      h1 = '0; h2 = '0; lvl = '0;
      for (int i = 0; i < 4; i++) run[i] = 0;
      m_func = 0; m_amp = 0; m_peri = 0; m_sel = 0; m_k = 0;
      m_upd = 1'b0; m_pp = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (h2[i] != lvl[i]) begin
          run[i]++;
          if (run[i] == DEB + 1) begin
            lvl[i] = h2[i];
            run[i] = 0;
            p[i] = h2[i];
          end
        end else run[i] = 0;
      end
      h2 = h1;
      h1 = b;
      if (p[0]) m_func = (m_func + 1) % 5;
      if (p[1]) m_amp = (m_amp + 1) % 4;
      if (p[2]) m_peri = (m_peri + 1) % 4;
      if (p[3]) begin
        m_sel = (m_sel + 1) % 4;
        m_k = 0;
      end else m_k++;
      m_pp = m_upd;
      m_upd = p[0] | p[2] | p[3];
    end
    #1;
    if (peri_posedge == 3'd1) pp_cnt++;
    chk("func_cnt", 8'(func_cnt), 8'(m_func));
    chk("amp_cnt", 8'(amp_cnt), 8'(m_amp));
    chk("peri_cnt", 8'(peri_cnt), 8'(m_peri));
    chk("freq_sel", 8'(freq_sel), 8'(m_sel));
    chk("freq_dy", 8'(freq_dy), 8'(m_sel == 0 ? 0 : m_k % (m_sel + 1)));
    chk("peri_posedge", 8'(peri_posedge), {7'd0, m_pp});
  endtask

  task automatic press(input logic [3:0] b, input int hold, input int rel);
    for (int i = 0; i < hold; i++) step(b, 1'b0);
    for (int i = 0; i < rel; i++) step(4'b0000, 1'b0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);
    pp_cnt = 0;
  endtask

  initial begin
    do_reset();
    chk("reset_func", 8'(func_cnt), 8'd0);
    chk("reset_pp", 8'(peri_posedge), 8'd0);
    // single long hold: one update on edge DEB+3, no auto-repeat
    for (int i = 1; i <= 10; i++) begin
      step(4'b0001, 1'b0);
      if (i == 6) chk("hold_func_before", 8'(func_cnt), 8'd0);
      if (i == 7) chk("hold_func_at7", 8'(func_cnt), 8'd1);
    end
    press(4'b0000, 0, 10);
    chk("hold_func_final", 8'(func_cnt), 8'd1);
    chk("hold_pp_count", 8'(pp_cnt), 8'd1);
    // five clean presses wrap func_cnt
    do_reset();
    for (int n = 1; n <= 5; n++) begin
      press(4'b0001, 8, 10);
      chk("func_seq", 8'(func_cnt), 8'(n % 5));
    end
    // bouncing amp then a steady hold
    do_reset();
    for (int i = 0; i < 2; i++) begin
      step(4'b0010, 1'b0);
      step(4'b0000, 1'b0);
    end
    press(4'b0010, 6, 10);
    chk("amp_bounce", 8'(amp_cnt), 8'd1);
    chk("amp_no_pp", 8'(pp_cnt), 8'd0);
    // three freq presses
    for (int n = 0; n < 3; n++) press(4'b1000, 8, 10);
    chk("freq_sel3", 8'(freq_sel), 8'd3);
    // simultaneous peri and freq
    do_reset();
    press(4'b1100, 8, 10);
    chk("sim_peri", 8'(peri_cnt), 8'd1);
    chk("sim_freq", 8'(freq_sel), 8'd1);
    chk("sim_pp_count", 8'(pp_cnt), 8'd1);
    // back-to-back updates give two strobe cycles
    do_reset();
    step(4'b0001, 1'b0);
    press(4'b0101, 9, 10);
    chk("b2b_pp_count", 8'(pp_cnt), 8'd2);
    // reset during CHK_PRESS with peri held
    do_reset();
    for (int i = 0; i < 4; i++) step(4'b0100, 1'b0);
    step(4'b0100, 1'b1);
    step(4'b0100, 1'b1);
    chk("rst_mid_peri", 8'(peri_cnt), 8'd0);
    pp_cnt = 0;
    press(4'b0100, 12, 10);
    chk("rst_held_peri", 8'(peri_cnt), 8'd1);
    chk("rst_held_pp", 8'(pp_cnt), 8'd1);
    // random activity with occasional reset
    rnd = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) rnd[i] = ~rnd[i];
      step(rnd, $urandom_range(0, 299) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
